cam_line_buffer: RTL and testbench
==================================

// Module: cam_line_buffer
// PURPOSE
//  Ping-pong line buffer between the camera pixel stream and the HDMI timing/debug stage.
//  Stores camera lines in RGB444 and replays each line on the display read strobe as RGB888.
//  Supplies the display stage's Mem_Read/Mem_Data/FraimSync interface in the same clk domain.
//  Flags overflow (camera faster than display) and underrun (display reads an empty line).
// PARAMETERS
//  LINE_W  640  pixels per line; also number of reads per display line
//  AW      10   bank address width; 2**AW >= LINE_W
//  CNT_W   16   width of the statistics counters (used only with LBUF_STATS_EN)
// PORTS
//  clk           in   1      pixel clock; all logic rising-edge
//  rstn          in   1      asynchronous, active-low reset
//  cam_valid     in   1      camera pixel qualifier
//  cam_data      in   12     pixel {R[11:8],G[7:4],B[3:0]}
//  cam_sol       in   1      start of line; valid only with cam_valid, marks pixel 0
//  cam_sof       in   1      start of frame; valid only with cam_valid, implies cam_sol
//  rd_en         in   1      display read strobe (Mem_Read); one pixel per cycle
//  rd_frame_rst  in   1      display frame restart (VSync low); aborts partial read
//  rd_data       out  24     {R8,G8,B8}, 1-cycle latency after rd_en (Mem_Data)
//  frame_sync    out  1      frame parity; toggles on each accepted cam_sof (FraimSync)
//  line_ready    out  1      bank at the read pointer is full
//  overflow      out  1      1-cycle pulse: camera line dropped
//  underrun      out  1      1-cycle pulse: read started on an empty bank
//  ovf_cnt       out  CNT_W  dropped-line count
//  udr_cnt       out  CNT_W  underrun-line count
// BEHAVIOUR
//  Reset: all outputs 0; full[1:0]=0; wr_bank=rd_bank=0; wr_addr=rd_addr=0; wr_drop=0.
//  Storage: two banks of LINE_W x 12b, one per write/read side; full[b] is the only handshake.
//  Write side, on cam_valid:
//   - cam_sol (or cam_sof): pixel goes to address 0 of wr_bank; wr_addr<=1; wr_drop<=full[wr_bank].
//   - full[wr_bank]=1 at cam_sol: line dropped; overflow pulses next cycle; bank left untouched.
//   - write only when !wr_drop; pixels at wr_addr>=LINE_W are discarded (no wrap).
//   - write at LINE_W-1: full[wr_bank]<=1; wr_bank toggles; wr_addr<=LINE_W (idle until next sol).
//   - cam_sof: also wr_bank<=rd_bank^full[rd_bank] (next free bank) and frame_sync toggles;
//     any partial line in progress is abandoned (bank stays not full).
//   - pixels before the first cam_sol after reset are ignored.
//  Read side, on rd_en:
//   - rd_addr==0: latch rd_empty<=!full[rd_bank]; if empty, underrun pulses next cycle.
//   - rd_data(t+1) = rd_empty ? 24'h000000 : {R,R,G,G,B,B} (nibble replication) of bank[rd_addr].
//   - rd_addr increments; read at LINE_W-1: full[rd_bank]<=0 (if it was full), rd_bank toggles, rd_addr<=0.
//   - no rd_en: rd_data holds its last value.
//  rd_frame_rst=1: rd_addr<=0; if rd_addr!=0, full[rd_bank]<=0 and rd_bank toggles; has priority over rd_en.
//  Simultaneous write-complete and read-complete in one cycle: both full bits update (always different banks).
//  A bank is never written while full and never read unless full, so no read/write address conflict.
//  line_ready = full[rd_bank], registered.
// CONFIGURATION
//  LBUF_STATS_EN defined: ovf_cnt/udr_cnt increment on each overflow/underrun pulse, saturate at all-ones,
//   clear on reset only.
//  LBUF_STATS_EN undefined: counters are not built; ovf_cnt and udr_cnt are tied to 0. Pulses unaffected.
// TESTING
//  1 sol + 640 pixels data=i[11:0], then 640 rd_en -> rd_data(k+1)=expand(k), e.g. k=0x123 -> 24'h112233;
//    line_ready 1->0 after last read; no underrun.
//  2 640 rd_en with no line written -> rd_data=0 for all 640; underrun pulses once; udr_cnt=1 (macro on).
//  3 write 3 lines with no reads -> overflow pulses once at line 3; reads return lines 1 and 2; ovf_cnt=1.
//  4 cam_sof after 300 pixels of a line, then full line -> frame_sync toggles; read returns only new line.
//  5 rstn low mid-read (rd_addr=200) -> all outputs 0 immediately; next read after reset underruns.
//  6 rd_frame_rst at rd_addr=100 -> bank released, rd_addr=0; next read uses the other bank.

Source files
------------

// File: rtl/cam_line_buffer.sv
// -----------------------------------------------------------------------------
// cam_line_buffer
//
// Ping-pong line buffer between the camera pixel stream and the HDMI
// timing/debug stage. Camera lines are stored as RGB444 in one of two banks and
// replayed on the display read strobe as RGB888 (nibble replication). Both
// sides run in the same clk domain. A per-bank "full" bit is the only handshake
// between the writer and the reader.
//
// Optional feature: define LBUF_STATS_EN to build saturating overflow/underrun
// line counters. Without it, ovf_cnt/udr_cnt are tied to zero. The
// overflow/underrun pulses are present in both builds.
//
// Ports
//   clk           pixel clock, all logic on the rising edge
//   rstn          asynchronous active-low reset
//   cam_valid     camera pixel qualifier
//   cam_data      camera pixel {R[11:8],G[7:4],B[3:0]}
//   cam_sol       start of line (with cam_valid), marks pixel 0
//   cam_sof       start of frame (with cam_valid), implies start of line
//   rd_en         display read strobe, one pixel per cycle
//   rd_frame_rst  display frame restart, aborts a partial line read
//   rd_data       {R8,G8,B8}, one cycle after rd_en; holds without rd_en
//   frame_sync    frame parity, toggles on each accepted cam_sof
//   line_ready    bank at the read pointer holds a complete line
//   overflow      1-cycle pulse: a camera line was dropped
//   underrun      1-cycle pulse: a display line started on an empty bank
//   ovf_cnt       dropped-line count (LBUF_STATS_EN only)
//   udr_cnt       underrun-line count (LBUF_STATS_EN only)
// -----------------------------------------------------------------------------
module cam_line_buffer #(
  parameter int LINE_W = 640,
  parameter int AW     = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cam_valid,
  input  logic [11:0]      cam_data,
  input  logic             cam_sol,
  input  logic             cam_sof,
  input  logic             rd_en,
  input  logic             rd_frame_rst,
  output logic [23:0]      rd_data,
  output logic             frame_sync,
  output logic             line_ready,
  output logic             overflow,
  output logic             underrun,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] udr_cnt
);

  // Last valid pixel address, and the write-side "line finished" park value.
  // The write address is one bit wider so it can hold LINE_W even when
  // LINE_W == 2**AW.
  localparam logic [AW-1:0] RD_LAST = AW'(LINE_W - 1);
  localparam logic [AW:0]   WR_END  = (AW + 1)'(LINE_W);
  localparam logic [AW:0]   WR_ONE  = (AW + 1)'(1);

  function automatic logic [23:0] expand444(input logic [11:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

  // Line storage: bank index first, pixel address second.
  logic [11:0]   mem_q [2][LINE_W];

  logic [1:0]    full_q, full_d;

  logic          wr_bank_q, wr_bank_d;
  logic [AW:0]   wr_addr_q, wr_addr_d;
  logic          wr_drop_q, wr_drop_d;
  logic          wr_act_q,  wr_act_d;

  logic          rd_bank_q,  rd_bank_d;
  logic [AW-1:0] rd_addr_q,  rd_addr_d;
  logic          rd_empty_q, rd_empty_d;

  logic [23:0]   rd_data_q, rd_data_d;
  logic          fsync_q,   fsync_d;
  logic          lready_q,  lready_d;
  logic          ovf_q,     ovf_d;
  logic          udr_q,     udr_d;

  logic          we;
  logic          wbank;
  logic [AW-1:0] waddr;
  logic          sol_bank;
  logic          rd_is_empty;

  // ---- next-state: write side, then read side ----
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    wr_drop_d   = wr_drop_q;
    wr_act_d    = wr_act_q;
    fsync_d     = fsync_q;
    ovf_d       = 1'b0;
    we          = 1'b0;
    wbank       = wr_bank_q;
    waddr       = '0;

    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    rd_empty_d  = rd_empty_q;
    rd_data_d   = rd_data_q;
    udr_d       = 1'b0;
    rd_is_empty = rd_empty_q;

    // At start of frame the writer jumps to the bank the reader will want
    // next: the read bank itself if it is free, otherwise the other one.
    sol_bank = cam_sof ? (rd_bank_q ^ full_q[rd_bank_q]) : wr_bank_q;

    if (cam_valid) begin
      if (cam_sol || cam_sof) begin
        if (cam_sof) begin
          fsync_d = ~fsync_q;
        end
        // Any partial line is simply abandoned: its bank never became full.
        wr_act_d  = 1'b1;
        wr_bank_d = sol_bank;
        wr_addr_d = WR_ONE;
        wr_drop_d = full_q[sol_bank];
        ovf_d     = full_q[sol_bank];
        if (!full_q[sol_bank]) begin
          we    = 1'b1;
          wbank = sol_bank;
          waddr = '0;
        end
      end else if (wr_act_q && (wr_addr_q < WR_END)) begin
        // A dropped line still walks its address so that it ends at LINE_W
        // like any other line, but it never touches the (full) bank.
        wr_addr_d = wr_addr_q + 1'b1;
        if (!wr_drop_q) begin
          we    = 1'b1;
          wbank = wr_bank_q;
          waddr = wr_addr_q[AW-1:0];
        end
      end

      if (we && (waddr == RD_LAST)) begin
        full_d[wbank] = 1'b1;
        wr_bank_d     = ~wbank;
        wr_addr_d     = WR_END;
      end
    end

    // A line is released only if it was full when its read began; an empty
    // read must not discard a line the writer completed meanwhile.
    if (rd_frame_rst) begin
      rd_addr_d = '0;
      if (rd_addr_q != '0) begin
        if (!rd_empty_q) begin
          full_d[rd_bank_q] = 1'b0;
        end
        rd_bank_d = ~rd_bank_q;
      end
    end else if (rd_en) begin
      rd_is_empty = (rd_addr_q == '0) ? ~full_q[rd_bank_q] : rd_empty_q;
      rd_empty_d  = rd_is_empty;
      udr_d       = (rd_addr_q == '0) && rd_is_empty;
      rd_data_d   = rd_is_empty ? 24'h000000 : expand444(mem_q[rd_bank_q][rd_addr_q]);
      if (rd_addr_q == RD_LAST) begin
        if (!rd_is_empty) begin
          full_d[rd_bank_q] = 1'b0;
        end
        rd_bank_d = ~rd_bank_q;
        rd_addr_d = '0;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end

    lready_d = full_d[rd_bank_d];
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_drop_q  <= 1'b0;
      wr_act_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_empty_q <= 1'b0;
      rd_data_q  <= 24'h000000;
      fsync_q    <= 1'b0;
      lready_q   <= 1'b0;
      ovf_q      <= 1'b0;
      udr_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      wr_drop_q  <= wr_drop_d;
      wr_act_q   <= wr_act_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      rd_empty_q <= rd_empty_d;
      rd_data_q  <= rd_data_d;
      fsync_q    <= fsync_d;
      lready_q   <= lready_d;
      ovf_q      <= ovf_d;
      udr_q      <= udr_d;
    end
  end

  // ---- line storage (no reset: contents qualified by full bits) ----
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wbank][waddr] <= cam_data;
    end
  end

`ifdef LBUF_STATS_EN
  logic [CNT_W-1:0] ovf_cnt_q;
  logic [CNT_W-1:0] udr_cnt_q;

  // ---- statistics counters, saturating ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt_q <= '0;
      udr_cnt_q <= '0;
    end else begin
      if (ovf_d && !(&ovf_cnt_q)) begin
        ovf_cnt_q <= ovf_cnt_q + 1'b1;
      end
      if (udr_d && !(&udr_cnt_q)) begin
        udr_cnt_q <= udr_cnt_q + 1'b1;
      end
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udr_cnt = udr_cnt_q;
`else
  assign ovf_cnt = '0;
  assign udr_cnt = '0;
`endif

  assign rd_data    = rd_data_q;
  assign frame_sync = fsync_q;
  assign line_ready = lready_q;
  assign overflow   = ovf_q;
  assign underrun   = udr_q;

endmodule

// File: tb/tb_cam_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_cam_line_buffer
//
// Bench for cam_line_buffer. A line-level reference model keeps each bank as a
// queue of camera pixels and replays a snapshot of the queue when a display
// line starts; one compare process checks every DUT output against it on each
// falling clock edge. Directed scenarios add literal expectations, then a
// randomized camera/display phase runs both sides concurrently.
// -----------------------------------------------------------------------------
module tb_cam_line_buffer;
  localparam int LINE_W = 640;
  localparam int AW     = 10;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cam_valid;
  logic [11:0]      cam_data;
  logic             cam_sol;
  logic             cam_sof;
  logic             rd_en;
  logic             rd_frame_rst;
  logic [23:0]      rd_data;
  logic             frame_sync;
  logic             line_ready;
  logic             overflow;
  logic             underrun;
  logic [CNT_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] udr_cnt;

  always #5 clk = ~clk;

  cam_line_buffer #(.LINE_W(LINE_W), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cam_valid    (cam_valid),
    .cam_data     (cam_data),
    .cam_sol      (cam_sol),
    .cam_sof      (cam_sof),
    .rd_en        (rd_en),
    .rd_frame_rst (rd_frame_rst),
    .rd_data      (rd_data),
    .frame_sync   (frame_sync),
    .line_ready   (line_ready),
    .overflow     (overflow),
    .underrun     (underrun),
    .ovf_cnt      (ovf_cnt),
    .udr_cnt      (udr_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_seen = 0;
  int udr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // RGB444 -> RGB888: multiplying a nibble by 0x11 duplicates it.
  function automatic logic [23:0] to888(input logic [11:0] p);
    return 24'(p[11:8]) * 24'h110000 + 24'(p[7:4]) * 24'h001100 + 24'(p[3:0]) * 24'h000011;
  endfunction

  // ---------------- reference model ----------------
  logic [11:0]      q0[$];
  logic [11:0]      q1[$];
  logic [11:0]      cur[$];
  bit   [1:0]       m_full;
  bit               m_rb, m_wb;
  int               m_wstate;   // 0 not in a line, 1 storing a line, 2 dropping a line
  int               m_rpos;
  bit               m_rempty;
  logic [23:0]      m_data;
  bit               m_fs, m_lr, m_ovf, m_udr;
  logic [CNT_W-1:0] m_ovfc, m_udrc;
  bit   [1:0]       f0;
  bit               rb0, tgt;

  task automatic q_clear(input bit b);
    if (b) q1.delete(); else q0.delete();
  endtask

  task automatic q_push(input bit b, input logic [11:0] p);
    if (b) q1.push_back(p); else q0.push_back(p);
  endtask

  function automatic int q_size(input bit b);
    return b ? q1.size() : q0.size();
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q0.delete(); q1.delete(); cur.delete();
      m_full = 2'b00; m_rb = 0; m_wb = 0; m_wstate = 0; m_rpos = 0; m_rempty = 0;
      m_data = '0; m_fs = 0; m_lr = 0; m_ovf = 0; m_udr = 0; m_ovfc = '0; m_udrc = '0;
    end else begin
      f0 = m_full; rb0 = m_rb; m_ovf = 0; m_udr = 0;
      // display side
      if (rd_frame_rst) begin
        if (m_rpos != 0) begin
          if (!m_rempty) m_full[rb0] = 0;
          m_rb = !rb0;
        end
        m_rpos = 0;
      end else if (rd_en) begin
        if (m_rpos == 0) begin
          m_rempty = !f0[rb0];
          m_udr    = m_rempty;
          cur.delete();
          if (!m_rempty) begin
            if (rb0) cur = q1; else cur = q0;
          end
        end
        if (m_rempty) m_data = 24'h0;
        else          m_data = to888(cur.pop_front());
        m_rpos++;
        if (m_rpos == LINE_W) begin
          if (!m_rempty) m_full[rb0] = 0;
          m_rb = !rb0; m_rpos = 0;
        end
      end
      // camera side
      if (cam_valid) begin
        if (cam_sol || cam_sof) begin
          if (cam_sof) begin
            m_fs = !m_fs;
            tgt  = f0[rb0] ? !rb0 : rb0;
          end else begin
            tgt = m_wb;
          end
          m_wb = tgt;
          if (f0[tgt]) begin
            m_ovf = 1; m_wstate = 2;
          end else begin
            q_clear(tgt); q_push(tgt, cam_data); m_wstate = 1;
          end
        end else if (m_wstate == 1) begin
          q_push(m_wb, cam_data);
        end
        if (m_wstate == 1 && q_size(m_wb) == LINE_W) begin
          m_full[m_wb] = 1; m_wb = !m_wb; m_wstate = 0;
        end
      end
`ifdef LBUF_STATS_EN
      if (m_ovf && m_ovfc != '1) m_ovfc++;
      if (m_udr && m_udrc != '1) m_udrc++;
`endif
      m_lr = m_full[m_rb];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("rd_data",    32'(rd_data),    32'(m_data));
    check("line_ready", 32'(line_ready), 32'(m_lr));
    check("frame_sync", 32'(frame_sync), 32'(m_fs));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("underrun",   32'(underrun),   32'(m_udr));
    check("ovf_cnt",    32'(ovf_cnt),    32'(m_ovfc));
    check("udr_cnt",    32'(udr_cnt),    32'(m_udrc));
    if (overflow === 1'b1) ovf_seen++;
    if (underrun === 1'b1) udr_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cam_valid = 0; cam_sol = 0; cam_sof = 0; cam_data = '0; rd_en = 0; rd_frame_rst = 0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic write_px(input int n, input logic [11:0] base, input bit sof);
    for (int i = 0; i < n; i++) begin
      cam_valid = 1'b1;
      cam_sol   = (i == 0);
      cam_sof   = (i == 0) && sof;
      cam_data  = base + 12'(i);
      cyc();
    end
    cam_valid = 0; cam_sol = 0; cam_sof = 0;
  endtask

  task automatic read_n(input int n, input int ki, input logic [23:0] kexp, input string nm);
    for (int k = 0; k < n; k++) begin
      rd_en = 1'b1;
      cyc();
      if (k == ki) check(nm, 32'(rd_data), 32'(kexp));
    end
    rd_en = 1'b0;
  endtask

  int u0, o0, exp_cnt1;

  initial begin
`ifdef LBUF_STATS_EN
    exp_cnt1 = 1;
`else
    exp_cnt1 = 0;
`endif
    do_reset();
    check("rst_rd_data",    32'(rd_data),    32'h0);
    check("rst_frame_sync", 32'(frame_sync), 32'h0);
    check("rst_line_ready", 32'(line_ready), 32'h0);
    check("rst_overflow",   32'(overflow),   32'h0);
    check("rst_underrun",   32'(underrun),   32'h0);
    check("rst_ovf_cnt",    32'(ovf_cnt),    32'h0);
    check("rst_udr_cnt",    32'(udr_cnt),    32'h0);

    // 1: one line written then read back
    u0 = udr_seen;
    write_px(LINE_W, 12'h000, 1'b0);
    check("t1_ready_after_write", 32'(line_ready), 32'h1);
    read_n(LINE_W, 'h123, 24'h112233, "t1_pix_0x123");
    check("t1_ready_after_read", 32'(line_ready), 32'h0);
    check("t1_no_underrun", 32'(udr_seen - u0), 32'd0);

    // 2: reading with nothing written
    u0 = udr_seen;
    read_n(LINE_W, LINE_W - 1, 24'h000000, "t2_last_pix_zero");
    check("t2_underrun_pulses", 32'(udr_seen - u0), 32'd1);
    check("t2_udr_cnt", 32'(udr_cnt), 32'(exp_cnt1));

    // 3: three lines, no reads -> third dropped
    do_reset();
    o0 = ovf_seen; u0 = udr_seen;
    write_px(LINE_W, 12'd100, 1'b0);
    write_px(LINE_W, 12'd200, 1'b0);
    write_px(LINE_W, 12'd300, 1'b0);
    check("t3_overflow_pulses", 32'(ovf_seen - o0), 32'd1);
    check("t3_ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt1));
    read_n(LINE_W, 5, 24'h006699, "t3_line1_pix5");
    read_n(LINE_W, 5, 24'h00CCDD, "t3_line2_pix5");
    check("t3_no_underrun", 32'(udr_seen - u0), 32'd0);
    check("t3_ready_end", 32'(line_ready), 32'h0);

    // 4: frame start abandons a partial line
    do_reset();
    write_px(300, 12'h111, 1'b0);
    write_px(LINE_W, 12'h800, 1'b1);
    check("t4_frame_sync", 32'(frame_sync), 32'h1);
    read_n(LINE_W, 1, 24'h880011, "t4_pix1");
    check("t4_ready_end", 32'(line_ready), 32'h0);

    // 5: asynchronous reset in the middle of a read
    do_reset();
    write_px(LINE_W, 12'h000, 1'b1);
    read_n(200, 199, 24'h00CC77, "t5_pix199");
    check("t5_ready_before", 32'(line_ready), 32'h1);
    check("t5_fsync_before", 32'(frame_sync), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("t5_rst_rd_data", 32'(rd_data),    32'h0);
    check("t5_rst_ready",   32'(line_ready), 32'h0);
    check("t5_rst_fsync",   32'(frame_sync), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    u0 = udr_seen;
    read_n(LINE_W, 0, 24'h000000, "t5_post_rst_pix0");
    check("t5_underrun_pulses", 32'(udr_seen - u0), 32'd1);

    // 6: display frame restart mid-line releases the bank
    do_reset();
    write_px(LINE_W, 12'h000, 1'b0);
    write_px(LINE_W, 12'h400, 1'b0);
    u0 = udr_seen;
    read_n(100, 99, 24'h006633, "t6_pix99");
    rd_frame_rst = 1'b1;
    cyc();
    rd_frame_rst = 1'b0;
    check("t6_ready_after_rst", 32'(line_ready), 32'h1);
    read_n(LINE_W, 0, 24'h440000, "t6_other_bank_pix0");
    check("t6_no_underrun", 32'(udr_seen - u0), 32'd0);
    check("t6_ready_end", 32'(line_ready), 32'h0);

    // randomized concurrent camera and display traffic
    do_reset();
    fork
      begin : cam_proc
        bit in_line = 0;
        int idx = 0;
        for (int c = 0; c < 30000; c++) begin
          cam_valid = 0; cam_sol = 0; cam_sof = 0; cam_data = 12'($urandom);
          if (!in_line) begin
            if ($urandom_range(0, 99) < 3) begin
              in_line = 1; idx = 0;
            end else if ($urandom_range(0, 199) == 0) begin
              cam_valid = 1;
            end
          end
          if (in_line && $urandom_range(0, 7) != 0) begin
            cam_valid = 1;
            if (idx == 0) begin
              cam_sol = 1; cam_sof = ($urandom_range(0, 5) == 0);
            end else if ($urandom_range(0, 999) == 0) begin
              cam_sol = 1; cam_sof = 1'($urandom_range(0, 1)); idx = 0;
            end
            idx++;
            if (idx == LINE_W) in_line = 0;
          end
          cyc();
        end
        cam_valid = 0; cam_sol = 0; cam_sof = 0;
      end
      begin : rd_proc
        bit rd_line = 0;
        int ridx = 0;
        for (int c = 0; c < 30000; c++) begin
          rd_en = 0; rd_frame_rst = 0;
          if (!rd_line) begin
            if ($urandom_range(0, 99) < 2) begin
              rd_line = 1; ridx = 0;
            end else if ($urandom_range(0, 499) == 0) begin
              rd_frame_rst = 1;
            end
          end else if ($urandom_range(0, 1999) == 0) begin
            rd_frame_rst = 1; rd_en = 1'($urandom_range(0, 1)); rd_line = 0;
          end else if ($urandom_range(0, 9) != 0) begin
            rd_en = 1; ridx++;
            if (ridx == LINE_W) rd_line = 0;
          end
          cyc();
        end
        rd_en = 0; rd_frame_rst = 0;
      end
    join
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
